pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program-counter unit; successor to the single-register PC.
Holds the fetch address and computes the next PC from a registered op select: sequential, relative branch, absolute jump, call and return.
Contains an internal return-address stack (RAS) with overflow/underflow reporting.
Sits at the front of the fetch stage; hazard logic drives pc_write (stall) and control logic drives op.

Parameters:
WIDTH, 16, PC/address width in bits
RESET_VECTOR, 0, PC value after reset (WIDTH bits)
INC, 2, sequential increment in address units (instruction size)
RAS_DEPTH, 4, return-address stack entries (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
pc_write  input  1  1 = advance PC per op this cycle; 0 = stall, all state held
op  input  3  next-PC operation (encoding in Behaviour)
target  input  WIDTH  absolute address for JMP/CALL
offset  input  WIDTH  two's-complement byte offset for BR
pc_out  output  WIDTH  current PC (registered)
ras_count  output  clog2(RAS_DEPTH+1)  valid RAS entries
ras_full  output  1  ras_count == RAS_DEPTH
ras_empty  output  1  ras_count == 0
ras_ovf  output  1  sticky: CALL executed while full
ras_unf  output  1  sticky: RET executed while empty

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on clk rising edge, overrides all other inputs.
- Reset values: pc_out=RESET_VECTOR, ras_count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0. Stack contents don't-care.
- All outputs are registered or derived from registers; no combinational input->output path.
- Latency: op applied in cycle N is visible on pc_out after edge N+1.
- Op encoding:
  - 0 SEQ: pc+INC.
  - 1 BR: pc+offset.
  - 2 JMP: target.
  - 3 CALL: target; push pc+INC.
  - 4 RET: pop top into pc.
  - 5-7 reserved: behave as SEQ.
- Arithmetic: all sums are modulo 2^WIDTH; wrap-around is silent (0xFFFE+2 -> 0x0000).
- pc_write=0: pc_out, stack and counters hold regardless of op; sticky flags unchanged.
- CALL when full:
  - RAS is circular, so the push overwrites the oldest entry.
  - ras_count stays RAS_DEPTH; ras_ovf set.
  - The PC still jumps to target.
- RET when empty:
  - pc <= pc+INC (fallthrough).
  - ras_unf set; ras_count stays 0.
- RET after overflow returns the most recent RAS_DEPTH addresses in LIFO order; the oldest is lost.
- Sticky flags clear only on rst.
- Reset mid-sequence (e.g. during a CALL cycle): reset wins; no push occurs; stack empties.

Decomposition:
- Shared package pc_pkg:
  - op encodings as localparams OP_SEQ, OP_BR, OP_JMP, OP_CALL, OP_RET.
  - Default WIDTH/INC constants.
- One sub-module ras_stack (params WIDTH, RAS_DEPTH):
  - Circular LIFO with push, pop, top, count, full, empty.
  - Overwrite-on-full; pop-on-empty is a no-op.
- pc_sequencer holds the PC register, next-PC mux, adders and sticky flags.

Test Plan:
1. Reset then SEQ, pc_write=1 for 3 cycles -> pc_out 0,2,4,6; flags 0, ras_empty=1.
2. pc_write=0 for 2 cycles with op=JMP target=0x40 at pc=6 -> pc_out stays 6; then pc_write=1 -> 0x40 next cycle.
3. At pc=0x0010, BR offset=0xFFF8 (-8) -> 0x0008. At pc=0xFFFE, SEQ -> 0x0000 (wrap).
4. At pc=0x10, CALL 0x100; then at 0x100, CALL 0x200; then RET, RET -> pc_out 0x100, 0x200, 0x102, 0x12; ras_count 1,2,1,0.
5. RAS_DEPTH=4: five CALLs from pc=0 with targets 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_ovf=1, ras_full=1. Then five RETs -> pc_out 0x42, 0x32, 0x22, 0x12, then the fifth RET underflows to 0x14; ras_unf=1.
6. Assert rst during a CALL cycle with ras_count=2 -> next pc_out=RESET_VECTOR, ras_count=0, ras_ovf=ras_unf=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants for the program-counter sequencer: op encodings and defaults.
package pc_pkg;

   localparam logic [2:0] OP_SEQ  = 3'd0;
   localparam logic [2:0] OP_BR   = 3'd1;
   localparam logic [2:0] OP_JMP  = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;

   localparam int PC_WIDTH_DEFAULT = 16;
   localparam int PC_INC_DEFAULT   = 2;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry,
// so the most recent RAS_DEPTH addresses are always retained in LIFO order.
// A pop when empty is a no-op. push and pop are expected to be exclusive.
module ras_stack #(
   parameter int WIDTH     = 16,
   parameter int RAS_DEPTH = 4,
   localparam int CW       = $clog2(RAS_DEPTH + 1),
   localparam int PW       = $clog2(RAS_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [RAS_DEPTH];
   // wr_ptr points at the slot the next push will write; top sits just below it
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    top_idx;
   logic [PW-1:0]    next_wr;

   // Pointer arithmetic wraps explicitly so non-power-of-two depths work
   always_comb begin
      top_idx = (wr_ptr == '0) ? PW'(RAS_DEPTH - 1) : wr_ptr - 1'b1;
      next_wr = (wr_ptr == PW'(RAS_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
   end

   // Pointer and occupancy: count saturates at RAS_DEPTH on overwrite-push
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         wr_ptr <= next_wr;
         if (!full) count <= count + 1'b1;
      end else if (pop && !empty) begin
         wr_ptr <= top_idx;
         count  <= count - 1'b1;
      end
   end

   // Storage is not reset; contents are meaningless while count is zero
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= push_data;
   end

   assign top   = mem[top_idx];
   assign full  = (count == CW'(RAS_DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit at the front of fetch: holds the PC, selects the next PC
// from the op code (seq/branch/jump/call/return) and owns the return stack.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int               WIDTH        = PC_WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               INC          = PC_INC_DEFAULT,
   parameter int               RAS_DEPTH    = 4,
   localparam int              CW           = $clog2(RAS_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pc_write,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] target,
   input  logic [WIDTH-1:0] offset,
   output logic [WIDTH-1:0] pc_out,
   output logic [CW-1:0]    ras_count,
   output logic             ras_full,
   output logic             ras_empty,
   output logic             ras_ovf,
   output logic             ras_unf
);

   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] ras_top;
   logic             do_push;
   logic             do_pop;
   logic             set_ovf;
   logic             set_unf;

   // Next-PC mux; all sums wrap silently modulo 2^WIDTH
   always_comb begin
      pc_inc  = pc_out + INC_W;
      pc_next = pc_inc;
      do_push = 1'b0;
      do_pop  = 1'b0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      if (pc_write) begin
         case (op)
            OP_BR:   pc_next = pc_out + offset;
            OP_JMP:  pc_next = target;
            OP_CALL: begin
               pc_next = target;
               do_push = 1'b1;
               set_ovf = ras_full;
            end
            OP_RET: begin
               // Empty stack falls through to the sequential address
               if (ras_empty) set_unf = 1'b1;
               else begin
                  pc_next = ras_top;
                  do_pop  = 1'b1;
               end
            end
            default: pc_next = pc_inc;
         endcase
      end else begin
         pc_next = pc_out;
      end
   end

   // PC register and sticky error flags; reset beats everything
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_out  <= RESET_VECTOR;
         ras_ovf <= 1'b0;
         ras_unf <= 1'b0;
      end else begin
         pc_out <= pc_next;
         if (set_ovf) ras_ovf <= 1'b1;
         if (set_unf) ras_unf <= 1'b1;
      end
   end

   ras_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (do_push),
      .pop       (do_pop),
      .push_data (pc_inc),
      .top       (ras_top),
      .count     (ras_count),
      .full      (ras_full),
      .empty     (ras_empty)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized ops against a
// queue-based reference model of the PC and return stack.
module tb_pc_sequencer;

   localparam int          W     = 16;
   localparam int          DEPTH = 4;
   localparam logic [15:0] RV    = 16'h0000;
   localparam logic [15:0] INCV  = 16'd2;

   logic        clk;
   logic        rst;
   logic        pc_write;
   logic [2:0]  op;
   logic [15:0] target;
   logic [15:0] offset;
   logic [15:0] pc_out;
   logic [2:0]  ras_count;
   logic        ras_full, ras_empty, ras_ovf, ras_unf;

   int n_pass = 0;
   int n_total = 0;

   // reference model state
   logic [15:0] m_pc;
   logic [15:0] m_stk[$];
   logic        m_ovf, m_unf;

   pc_sequencer #(
      .WIDTH(W), .RESET_VECTOR(RV), .INC(2), .RAS_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .pc_write(pc_write), .op(op),
      .target(target), .offset(offset), .pc_out(pc_out),
      .ras_count(ras_count), .ras_full(ras_full), .ras_empty(ras_empty),
      .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle, advance the model, sample 1 time unit after the edge
   task automatic step(input logic r, input logic w, input logic [2:0] o,
                       input logic [15:0] t, input logic [15:0] f);
      rst = r; pc_write = w; op = o; target = t; offset = f;
      @(posedge clk);
      if (r) begin
         m_pc = RV; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end else if (w) begin
         case (o)
            3'd1: m_pc = m_pc + f;
            3'd2: m_pc = t;
            3'd3: begin
               m_stk.push_back(m_pc + INCV);
               if (m_stk.size() > DEPTH) begin
                  void'(m_stk.pop_front());
                  m_ovf = 1'b1;
               end
               m_pc = t;
            end
            3'd4: begin
               if (m_stk.size() > 0) m_pc = m_stk.pop_back();
               else begin m_pc = m_pc + INCV; m_unf = 1'b1; end
            end
            default: m_pc = m_pc + INCV;
         endcase
      end
      #1;
   endtask

   task automatic test_reset();
      step(1, 0, 3'd0, 0, 0);
      n_total++;
      if (pc_out !== RV) $display("FAIL reset_pc: got %h want %h", pc_out, RV);
      else n_pass++;
      n_total++;
      if ({ras_count, ras_empty, ras_full, ras_ovf, ras_unf} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0})
         $display("FAIL reset_flags: got cnt=%0d e=%b f=%b o=%b u=%b want 0 1 0 0 0",
                  ras_count, ras_empty, ras_full, ras_ovf, ras_unf);
      else n_pass++;
   endtask

   task automatic test_seq();
      logic [15:0] exp;
      for (int i = 1; i <= 3; i++) begin
         step(0, 1, 3'd0, 0, 0);
         exp = 16'(2 * i);
         n_total++;
         if (pc_out !== exp) $display("FAIL seq_pc: got %h want %h", pc_out, exp);
         else n_pass++;
      end
      n_total++;
      if ({ras_empty, ras_ovf, ras_unf} !== 3'b100)
         $display("FAIL seq_flags: got e=%b o=%b u=%b want 1 0 0", ras_empty, ras_ovf, ras_unf);
      else n_pass++;
   endtask

   task automatic test_stall();
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 3'd2, 16'h0040, 0);
         n_total++;
         if (pc_out !== 16'h0006) $display("FAIL stall_hold: got %h want 0006", pc_out);
         else n_pass++;
      end
      step(0, 1, 3'd2, 16'h0040, 0);
      n_total++;
      if (pc_out !== 16'h0040) $display("FAIL stall_release: got %h want 0040", pc_out);
      else n_pass++;
   endtask

   task automatic test_branch_wrap();
      step(0, 1, 3'd2, 16'h0010, 0);
      step(0, 1, 3'd1, 0, 16'hFFF8);
      n_total++;
      if (pc_out !== 16'h0008) $display("FAIL br_neg: got %h want 0008", pc_out);
      else n_pass++;
      step(0, 1, 3'd2, 16'hFFFE, 0);
      step(0, 1, 3'd0, 0, 0);
      n_total++;
      if (pc_out !== 16'h0000) $display("FAIL seq_wrap: got %h want 0000", pc_out);
      else n_pass++;
   endtask

   task automatic test_call_ret();
      logic [2:0]  ops [4] = '{3'd3, 3'd3, 3'd4, 3'd4};
      logic [15:0] tgs [4] = '{16'h0100, 16'h0200, 16'h0, 16'h0};
      logic [15:0] xpc [4] = '{16'h0100, 16'h0200, 16'h0102, 16'h0012};
      logic [2:0]  xct [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
      step(0, 1, 3'd2, 16'h0010, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, ops[i], tgs[i], 0);
         n_total++;
         if (pc_out !== xpc[i] || ras_count !== xct[i])
            $display("FAIL call_ret[%0d]: got pc=%h cnt=%0d want pc=%h cnt=%0d",
                     i, pc_out, ras_count, xpc[i], xct[i]);
         else n_pass++;
      end
   endtask

   task automatic test_overflow();
      logic [15:0] xpc [5] = '{16'h0042, 16'h0032, 16'h0022, 16'h0012, 16'h0014};
      step(1, 0, 3'd0, 0, 0);
      for (int i = 1; i <= 5; i++) step(0, 1, 3'd3, 16'(16 * i), 0);
      n_total++;
      if ({ras_ovf, ras_full, ras_unf, ras_count} !== {1'b1, 1'b1, 1'b0, 3'd4})
         $display("FAIL ovf_flags: got o=%b f=%b u=%b cnt=%0d want 1 1 0 4",
                  ras_ovf, ras_full, ras_unf, ras_count);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 3'd4, 0, 0);
         n_total++;
         if (pc_out !== xpc[i]) $display("FAIL ovf_ret[%0d]: got %h want %h", i, pc_out, xpc[i]);
         else n_pass++;
      end
      n_total++;
      if ({ras_unf, ras_ovf, ras_empty, ras_count} !== {1'b1, 1'b1, 1'b1, 3'd0})
         $display("FAIL unf_flags: got u=%b o=%b e=%b cnt=%0d want 1 1 1 0",
                  ras_unf, ras_ovf, ras_empty, ras_count);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      step(0, 1, 3'd3, 16'h0300, 0);
      step(0, 1, 3'd3, 16'h0400, 0);
      n_total++;
      if (ras_count !== 3'd2) $display("FAIL mid_pre_cnt: got %0d want 2", ras_count);
      else n_pass++;
      step(1, 1, 3'd3, 16'h0500, 0);
      n_total++;
      if ({pc_out, ras_count, ras_ovf, ras_unf, ras_empty} !== {RV, 3'd0, 1'b0, 1'b0, 1'b1})
         $display("FAIL mid_reset: got pc=%h cnt=%0d o=%b u=%b e=%b want %h 0 0 0 1",
                  pc_out, ras_count, ras_ovf, ras_unf, ras_empty, RV);
      else n_pass++;
   endtask

   task automatic test_random();
      logic r, w;
      logic [2:0] o;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 99) < 2);
         w = ($urandom_range(0, 99) < 80);
         // bias toward call/return so the stack overflows and underflows
         o = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(3, 4)) : 3'($urandom_range(0, 7));
         step(r, w, o, 16'($urandom), 16'($urandom));
         n_total++;
         if (pc_out !== m_pc || ras_count !== 3'(m_stk.size()) ||
             ras_full !== (m_stk.size() == DEPTH) || ras_empty !== (m_stk.size() == 0) ||
             ras_ovf !== m_ovf || ras_unf !== m_unf)
            $display("FAIL rand[%0d]: got pc=%h cnt=%0d f=%b e=%b o=%b u=%b want pc=%h cnt=%0d o=%b u=%b",
                     i, pc_out, ras_count, ras_full, ras_empty, ras_ovf, ras_unf,
                     m_pc, m_stk.size(), m_ovf, m_unf);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; pc_write = 1'b0; op = 3'd0; target = '0; offset = '0;
      m_pc = RV; m_ovf = 1'b0; m_unf = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_seq();
      test_stall();
      test_branch_wrap();
      test_call_ret();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
